rstack_ctrl: RTL and testbench

//  Pointer/control stage that sits directly upstream of the return stack memory.

---
 rtl/rstack_ctrl.sv | 120 ++++++++++++
 tb/tb_rstack_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rstack_ctrl.sv
// Return-stack pointer/control stage: turns push/pop requests into 1R1W memory
// accesses, tracks depth, and reports sticky overflow/underflow plus a high-water mark.
module rstack_ctrl #(
  parameter int WIDTH      = 4,
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] top,
  output logic                  empty,
  output logic                  full,
  output logic [WIDTH:0]        depth,
  output logic [WIDTH:0]        max_depth,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_din_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic [WIDTH-1:0]      mem_dout_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int             SIZE   = 2 ** WIDTH;
  localparam logic [WIDTH:0] SIZE_V = (WIDTH + 1)'(SIZE);
  localparam logic [WIDTH:0] ONE_V  = (WIDTH + 1)'(1);

  logic [WIDTH:0]   depth_q, depth_d;
  logic [WIDTH:0]   max_depth_q, max_depth_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             is_empty, is_full;
  logic             do_write, do_replace;
  logic             ovf_evt, unf_evt;
  logic [WIDTH-1:0] ptr, ptr_m1;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == SIZE_V);
  assign ptr      = depth_q[WIDTH-1:0];
  assign ptr_m1   = ptr - 1'b1;

  // Operation decode
  always_comb begin
    depth_d    = depth_q;
    do_write   = 1'b0;
    do_replace = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!is_full) begin
          do_write = 1'b1;
          depth_d  = depth_q + ONE_V;
        end else begin
          ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (!is_empty) depth_d = depth_q - ONE_V;
        else           unf_evt = 1'b1;
      end
      2'b11: begin
        do_write = 1'b1;
        if (!is_empty) do_replace = 1'b1;
        else           depth_d    = ONE_V;
      end
      default: ;
    endcase
  end

  // A new error wins over a simultaneous clear
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_evt) overflow_d  = 1'b1;
    if (unf_evt) underflow_d = 1'b1;
  end

  always_comb begin
    max_depth_d = max_depth_q;
    if (depth_d > max_depth_q) max_depth_d = depth_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q     <= '0;
      max_depth_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      max_depth_q <= max_depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Write strobe is gated by reset so no stray write escapes while held in reset
  assign mem_we        = do_write & reset_n;
  assign mem_din_addr  = do_replace ? ptr_m1 : ptr;
  assign mem_din       = push_data;
  assign mem_dout_addr = ptr_m1;

  assign top       = is_empty ? '0 : mem_dout;
  assign empty     = is_empty;
  assign full      = is_full;
  assign depth     = depth_q;
  assign max_depth = max_depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_rstack_ctrl.sv
// Bench for rstack_ctrl: behavioural memory plus a queue-based stack reference model,
// directed scenarios followed by randomized push/pop traffic.
module tb_rstack_ctrl;

  localparam int WIDTH = 4;
  localparam int DW    = 13;
  localparam int SIZE  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          push, pop, err_clr;
  logic [DW-1:0] push_data;
  logic [DW-1:0] top, mem_din, mem_dout;
  logic          empty, full, overflow, underflow, mem_we;
  logic [WIDTH:0] depth, max_depth;
  logic [WIDTH-1:0] mem_din_addr, mem_dout_addr;

  logic [DW-1:0] mem_arr [SIZE];

  int n_vec = 0;
  int n_bad = 0;

  int q[$];
  bit m_ovf, m_unf;
  int m_max;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem_arr[mem_din_addr] <= mem_din;
  assign mem_dout = mem_arr[mem_dout_addr];

  rstack_ctrl #(.WIDTH(WIDTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .push_data(push_data),
    .err_clr(err_clr), .top(top), .empty(empty), .full(full), .depth(depth),
    .max_depth(max_depth), .overflow(overflow), .underflow(underflow),
    .mem_we(mem_we), .mem_din_addr(mem_din_addr), .mem_din(mem_din),
    .mem_dout_addr(mem_dout_addr), .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_max = 0;
  endtask

  task automatic check_state();
    int sz;
    sz = q.size();
    chk("depth", depth, sz);
    chk("empty", empty, sz == 0);
    chk("full", full, sz == SIZE);
    chk("top", top, sz == 0 ? 0 : q[$]);
    chk("max_depth", max_depth, m_max);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("rd_addr", mem_dout_addr, (sz - 1) & (SIZE - 1));
  endtask

  // Apply one cycle of stimulus, check combinational and state outputs, then clock
  task automatic step(input bit p, input bit o, input logic [DW-1:0] d, input bit c);
    int sz, exp_addr;
    bit exp_we, new_o, new_u;
    push = p; pop = o; push_data = d; err_clr = c;
    #1;
    sz = q.size();
    check_state();
    exp_we   = p && (sz < SIZE || o);
    exp_addr = (p && o && sz > 0) ? sz - 1 : sz % SIZE;
    chk("mem_we", mem_we, exp_we);
    chk("wr_addr", mem_din_addr, exp_addr);
    if (p) chk("mem_din", mem_din, d);
    new_o = 0; new_u = 0;
    if (p && o && sz > 0)  q[sz-1] = d;
    else if (p) begin
      if (sz < SIZE) q.push_back(d);
      else new_o = 1;
    end else if (o) begin
      if (sz > 0) void'(q.pop_back());
      else new_u = 1;
    end
    m_ovf = new_o ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = new_u ? 1'b1 : (c ? 1'b0 : m_unf);
    if (q.size() > m_max) m_max = q.size();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 0; pop = 0; err_clr = 0; push_data = '0;
    reset_n = 0;
    #3;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_top", top, 0);
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    push = 0; pop = 0; err_clr = 0; push_data = '0; reset_n = 1;
    for (int i = 0; i < SIZE; i++) mem_arr[i] = '0;
    #1;
    do_reset();

    // three pushes then pops past empty
    for (int i = 0; i < 3; i++) step(1, 0, 13'h100 + 13'(i), 0);
    check_state();
    for (int i = 0; i < 4; i++) step(0, 1, '0, 0);
    check_state();
    chk("underflow_set", underflow, 1);

    // fill and overflow; push+pop at full replaces the top
    step(0, 0, '0, 1);
    for (int i = 0; i < SIZE; i++) step(1, 0, 13'h200 + 13'(i), 0);
    step(1, 0, 13'h1FFF, 0);
    check_state();
    chk("ovf_top", top, 13'h20F);
    step(1, 0, 13'h1FFF, 1);
    chk("ovf_wins_clr", overflow, 1);
    step(0, 0, '0, 1);
    chk("ovf_cleared", overflow, 0);
    step(1, 1, 13'h0BB, 0);

    // replace at depth 5, and push+pop on empty
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 13'h300 + 13'(i), 0);
    step(1, 1, 13'h0AA, 0);
    chk("replace_top", top, 13'h0AA);
    chk("replace_depth", depth, 5);
    for (int i = 0; i < 5; i++) step(0, 1, '0, 0);
    step(1, 1, 13'h055, 0);
    check_state();
    chk("pp_empty_unf", underflow, 0);

    // async reset mid-push at depth 7
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 13'h400 + 13'(i), 0);
    push = 1; push_data = 13'h777;
    #2;
    reset_n = 0;
    #1;
    chk("arst_depth", depth, 0);
    chk("arst_max", max_depth, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_empty", empty, 1);
    chk("arst_top", top, 0);
    push = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();
    check_state();

    // randomized traffic with push-heavy / pop-heavy / balanced phases
    for (int ph = 0; ph < 15; ph++) begin
      int bias;
      bias = ph % 3;
      for (int k = 0; k < 40; k++) begin
        int r;
        bit p, o, c;
        r = int'($urandom_range(99));
        case (bias)
          0: begin p = r < 75; o = (r % 7) == 0; end
          1: begin p = (r % 7) == 0; o = r < 75; end
          default: begin p = r[0]; o = r[1]; end
        endcase
        c = ($urandom_range(15) == 0);
        step(p, o, DW'($urandom), c);
      end
    end
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
